// File: rtl/ppu_pkg.sv
// Shared PPU definitions: access FSM states, address-space decode bounds and
// CPU-visible register indices.
package ppu_pkg;

    localparam int unsigned ADDR_W = 14;

    localparam logic [ADDR_W-1:0] CHR_TOP  = 14'h1FFF;
    localparam logic [ADDR_W-1:0] PAL_BASE = 14'h3F00;

    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StWrIssue,
        StRdIssue,
        StRdWait
    } state_e;

endpackage

// File: rtl/ppu_palette_ram.sv
// 32x6 palette RAM with the backdrop aliasing ($3F10/14/18/1C -> $3F00/04/08/0C)
// and an asynchronous read port.
module ppu_palette_ram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [5:0] wdata,
    output logic [5:0] rdata
);

    logic [4:0] idx;
    logic [5:0] mem_q [32];

    assign idx = (addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-facing PPUADDR/PPUDATA port: two-write address latch, buffered $2007 reads,
// auto-increment and nametable mirroring. Palette RAM is built with PPU_PALETTE_EN.
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        ppu_clk_in,
    input  logic        ppu_reset_n_in,
    input  logic [2:0]  reg_addr_in,
    input  logic        cpu_read_in,
    input  logic        cpu_write_in,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic        vram_inc32_in,
    input  logic        mirror_vertical_in,
    output logic        busy_out,
    output logic        vram_enable_out,
    output logic        vram_read_out,
    output logic        vram_write_out,
    output logic        cart_address_out,
    output logic [9:0]  vram_address_out,
    output logic [7:0]  vram_data_out,
    input  logic [7:0]  vram_data_in,
    output logic        chr_read_out,
    output logic        chr_write_out,
    output logic [12:0] chr_address_out,
    output logic [7:0]  chr_data_out,
    input  logic [7:0]  chr_data_in
);

    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] v_q, v_d;
    logic [5:0]        t_hi_q;
    logic              w_q, inc_q, tgt_chr_q, addr_set_q;
    logic [7:0]        rbuf_q;

    logic wr_addr, rd_status, wr_data, rd_data, idle;
    logic acc_wr, acc_rd, ext_issue, v_load, do_inc, capture, is_chr, pal_hit;
    logic [ADDR_W-1:0] step;

    assign wr_addr   = cpu_write_in && (reg_addr_in == REG_ADDR);
    assign rd_status = cpu_read_in && (reg_addr_in == REG_STATUS);
    assign wr_data   = cpu_write_in && (reg_addr_in == REG_DATA);
    assign rd_data   = cpu_read_in && (reg_addr_in == REG_DATA);
    assign idle      = (state_q == StIdle);
    assign busy_out  = !idle;
    assign acc_wr    = idle && wr_data;
    assign acc_rd    = idle && rd_data && !wr_data;
    assign is_chr    = (v_q <= CHR_TOP);
    assign v_load    = wr_addr && w_q;
    assign step      = inc_q ? 14'd32 : 14'd1;
    // A $2006 load during an access supersedes that access's increment.
    assign do_inc    = ((state_q == StWrIssue) || capture) && !addr_set_q;
    // Palette reads still fetch the underlying nametable byte into the buffer.
    assign ext_issue = acc_rd || (acc_wr && !pal_hit);

`ifdef PPU_PALETTE_EN
    logic [5:0] pal_rdata;

    assign pal_hit      = (v_q >= PAL_BASE);
    assign cpu_data_out = pal_hit ? {2'b00, pal_rdata} : rbuf_q;

    ppu_palette_ram u_palette (
        .clk   (ppu_clk_in),
        .rst_n (ppu_reset_n_in),
        .we    (acc_wr && pal_hit),
        .addr  (v_q[4:0]),
        .wdata (cpu_data_in[5:0]),
        .rdata (pal_rdata)
    );
`else
    assign pal_hit      = 1'b0;
    assign cpu_data_out = rbuf_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_wr) begin
                    state_d = StWrIssue;
                end else if (acc_rd) begin
                    state_d = StRdIssue;
                end
            end
            StWrIssue: state_d = StIdle;
            StRdIssue: begin
                state_d = StRdWait;
                cnt_d   = '0;
            end
            StRdWait: begin
                if (cnt_q == LAST_WAIT) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        v_d = v_q;
        if (v_load) begin
            v_d = {t_hi_q, cpu_data_in};
        end else if (do_inc) begin
            v_d = v_q + step;
        end
    end

    always_ff @(posedge ppu_clk_in or negedge ppu_reset_n_in) begin
        if (!ppu_reset_n_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge ppu_clk_in or negedge ppu_reset_n_in) begin
        if (!ppu_reset_n_in) begin
            v_q              <= '0;
            t_hi_q           <= '0;
            w_q              <= 1'b0;
            rbuf_q           <= '0;
            inc_q            <= 1'b0;
            tgt_chr_q        <= 1'b0;
            addr_set_q       <= 1'b0;
            vram_enable_out  <= 1'b0;
            vram_read_out    <= 1'b0;
            vram_write_out   <= 1'b0;
            cart_address_out <= 1'b0;
            vram_address_out <= '0;
            vram_data_out    <= '0;
            chr_read_out     <= 1'b0;
            chr_write_out    <= 1'b0;
            chr_address_out  <= '0;
            chr_data_out     <= '0;
        end else begin
            v_q <= v_d;
            if (wr_addr) begin
                w_q <= !w_q;
                if (!w_q) begin
                    t_hi_q <= cpu_data_in[5:0];
                end
            end else if (rd_status) begin
                w_q <= 1'b0;
            end

            if (acc_wr || acc_rd) begin
                addr_set_q <= 1'b0;
                inc_q      <= vram_inc32_in;
                tgt_chr_q  <= is_chr;
            end else if (v_load && !idle) begin
                addr_set_q <= 1'b1;
            end

            if (capture) begin
                rbuf_q <= tgt_chr_q ? chr_data_in : vram_data_in;
            end

            vram_enable_out <= 1'b0;
            vram_read_out   <= 1'b0;
            vram_write_out  <= 1'b0;
            chr_read_out    <= 1'b0;
            chr_write_out   <= 1'b0;
            if (ext_issue) begin
                if (is_chr) begin
                    chr_read_out    <= acc_rd;
                    chr_write_out   <= acc_wr;
                    chr_address_out <= v_q[12:0];
                    if (acc_wr) begin
                        chr_data_out <= cpu_data_in;
                    end
                end else begin
                    vram_enable_out  <= 1'b1;
                    vram_read_out    <= acc_rd;
                    vram_write_out   <= acc_wr;
                    vram_address_out <= v_q[9:0];
                    cart_address_out <= mirror_vertical_in ? v_q[10] : v_q[11];
                    if (acc_wr) begin
                        vram_data_out <= cpu_data_in;
                    end
                end
            end
        end
    end

endmodule
